// File: rtl/commit_trace_buffer.sv
// Commit-trace capture: packs retire activity into records held in a circular FIFO with cycle/instruction counters.
// Optional per-record cycle stamps are compiled in with COMMIT_TRACE_STAMP_EN.
module commit_trace_buffer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] inst,
    input  logic              reg_we,
    input  logic [3:0]        reg_dst,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              halt,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [3:0]        rd_flags,
    output logic [3:0]        rd_reg_dst,
    output logic [DATA_W-1:0] rd_reg_data,
    output logic [DATA_W-1:0] rd_mem_addr,
    output logic [DATA_W-1:0] rd_mem_data,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_inst,
    output logic [CYC_W-1:0]  rd_stamp,
    output logic [1:0]        state,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [CYC_W-1:0]  inst_count,
    output logic [CYC_W-1:0]  drop_count,
    output logic              overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } traceState_e;

    traceState_e curState, nextState;
    logic        capture;

    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] fifoCount, countNext;
    logic             isEvent, isRetire, isFull, popOk, pushOk, dropNow;
    logic             syncClear;

    logic [3:0]        flagsMem   [DEPTH];
    logic [3:0]        regDstMem  [DEPTH];
    logic [DATA_W-1:0] regDataMem [DEPTH];
    logic [DATA_W-1:0] memAddrMem [DEPTH];
    logic [DATA_W-1:0] memDataMem [DEPTH];
    logic [DATA_W-1:0] pcMem      [DEPTH];
    logic [DATA_W-1:0] instMem    [DEPTH];

    assign syncClear = !rst_n || clr;

    // State register
    always_ff @(posedge clk) begin
        if (syncClear) curState <= IDLE;
        else           curState <= nextState;
    end

    // Next state; the watchdog check uses the count at cycle start and suppresses capture
    always_comb begin
        nextState = curState;
        capture   = 1'b0;
        case (curState)
            IDLE: begin
                if (en) nextState = CAPTURE;
            end
            CAPTURE: begin
                if (cycle_count == CYC_W'(MAX_CYCLES)) begin
                    nextState = TIMEOUT;
                end else begin
                    capture = 1'b1;
                    if (halt) nextState = HALTED;
                end
            end
            default: ;
        endcase
    end

    assign state     = curState;
    assign isEvent   = capture && (reg_we || mem_re || mem_we || halt);
    assign isRetire  = capture && (halt || reg_we || mem_we);
    assign isFull    = (fifoCount == CNT_W'(DEPTH));
    assign popOk     = rd_valid && rd_ready;
    assign pushOk    = isEvent && (!isFull || popOk);
    assign dropNow   = isEvent && !pushOk;
    assign countNext = fifoCount + CNT_W'(pushOk) - CNT_W'(popOk);

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (syncClear) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
            fifoCount <= countNext;
            rd_valid  <= (countNext != '0);
        end
    end

    // Saturating counters and sticky overflow
    always_ff @(posedge clk) begin
        if (syncClear) begin
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (capture && cycle_count != '1) cycle_count <= cycle_count + CYC_W'(1);
            if (isRetire && inst_count != '1) inst_count <= inst_count + CYC_W'(1);
            if (dropNow && drop_count != '1) drop_count <= drop_count + CYC_W'(1);
            if (dropNow) overflow <= 1'b1;
        end
    end

    // Record storage; pointers alone define validity so no reset is needed here
    always_ff @(posedge clk) begin
        if (pushOk) begin
            flagsMem[wrPtr]   <= {halt, mem_re, mem_we, reg_we};
            regDstMem[wrPtr]  <= reg_dst;
            regDataMem[wrPtr] <= reg_we ? reg_data : '0;
            memAddrMem[wrPtr] <= mem_addr;
            memDataMem[wrPtr] <= mem_we ? mem_wdata : (mem_re ? mem_rdata : '0);
            pcMem[wrPtr]      <= pc;
            instMem[wrPtr]    <= inst;
        end
    end

    assign rd_flags    = flagsMem[rdPtr];
    assign rd_reg_dst  = regDstMem[rdPtr];
    assign rd_reg_data = regDataMem[rdPtr];
    assign rd_mem_addr = memAddrMem[rdPtr];
    assign rd_mem_data = memDataMem[rdPtr];
    assign rd_pc       = pcMem[rdPtr];
    assign rd_inst     = instMem[rdPtr];

`ifdef COMMIT_TRACE_STAMP_EN
    logic [CYC_W-1:0] stampMem [DEPTH];

    always_ff @(posedge clk) begin
        if (pushOk) stampMem[wrPtr] <= cycle_count;
    end

    assign rd_stamp = stampMem[rdPtr];
`else
    assign rd_stamp = '0;
`endif

endmodule
